// File: rtl/segments_fade_pkg.sv
// Segment geometry, segment id type, index helpers and walker state for the fading segment display.
package segments_fade_pkg;
  localparam int MAX_X_SEGMENT = 9;
  localparam int MAX_Y_SEGMENT = 16;
  localparam int MAX_Z_SEGMENT = 4;
  localparam int N_SEG = MAX_X_SEGMENT * MAX_Y_SEGMENT * MAX_Z_SEGMENT;
  localparam int IDX_W = $clog2(N_SEG);
  localparam int XW = $clog2(MAX_X_SEGMENT);
  localparam int YW = $clog2(MAX_Y_SEGMENT);
  localparam int ZW = $clog2(MAX_Z_SEGMENT);

  typedef logic [MAX_Z_SEGMENT-1:0][MAX_X_SEGMENT-1:0][MAX_Y_SEGMENT-1:0] seg_map_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [ZW-1:0] z;
  } seg_id_t;

  typedef enum logic [1:0] {W_IDLE, W_WALK, W_DONE} walk_state_e;

  function automatic logic [IDX_W-1:0] seg_idx(seg_id_t id);
    return IDX_W'((int'(id.x) * MAX_Y_SEGMENT + int'(id.y)) * MAX_Z_SEGMENT + int'(id.z));
  endfunction

  // z fastest, then y, then x: visits ids in ascending seg_idx order
  function automatic seg_id_t seg_id_next(seg_id_t id);
    seg_id_t n;
    n = id;
    if (id.z != ZW'(MAX_Z_SEGMENT-1)) n.z = id.z + 1'b1;
    else begin
      n.z = '0;
      if (id.y != YW'(MAX_Y_SEGMENT-1)) n.y = id.y + 1'b1;
      else begin
        n.y = '0;
        n.x = (id.x == XW'(MAX_X_SEGMENT-1)) ? '0 : id.x + 1'b1;
      end
    end
    return n;
  endfunction
endpackage

// File: rtl/segments_fade_if.sv
// Video-side bundle of the fading segment block: pixel position, blanks, segment matrix, mask load, outputs.
interface segments_fade_if import segments_fade_pkg::*; #(parameter int LEVEL_BITS = 8) ();
  logic                  fade_enable;
  logic                  mask_data_wr;
  logic [15:0]           mask_data;
  seg_map_t              segments;
  logic                  vblank_int;
  logic                  hblank_int;
  logic [9:0]            video_x;
  logic [9:0]            video_y;
  logic                  segment_en;
  logic [LEVEL_BITS-1:0] segment_level;
  logic                  walk_overrun;

  modport master (
    output fade_enable, mask_data_wr, mask_data, segments, vblank_int, hblank_int, video_x, video_y,
    input  segment_en, segment_level, walk_overrun
  );
  modport slave (
    input  fade_enable, mask_data_wr, mask_data, segments, vblank_int, hblank_int, video_x, video_y,
    output segment_en, segment_level, walk_overrun
  );
endinterface

// File: rtl/segments_fade_level_ram.sv
// Simple dual-port level store, registered read, no reset so it maps onto block RAM.
module segments_fade_level_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 576,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/segments_fade_mask.sv
// Pixel -> segment id lookup: square tiles of 2**(CLOCK_RATIO+1) px, per-column enable loaded by mask writes.
module segments_fade_mask import segments_fade_pkg::*; #(
  parameter int CLOCK_RATIO = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  video_x_i,
  input  logic [9:0]  video_y_i,
  input  logic        hblank_i,
  input  logic        vblank_i,
  input  logic        mask_wr_i,
  input  logic [15:0] mask_data_i,
  output seg_id_t     id_o,
  output logic        has_o
);
  localparam int TS = CLOCK_RATIO + 1;

  logic [MAX_Y_SEGMENT-1:0] col_en_q;
  logic [9:0] cx, cy;
  seg_id_t id_d;
  logic has_d;

  // tile column carries y in its low bits and z above; tile row is x
  always_comb begin
    cx = video_x_i >> TS;
    cy = video_y_i >> TS;
    id_d.x = cy[XW-1:0];
    id_d.y = cx[YW-1:0];
    id_d.z = cx[YW +: ZW];
    has_d = !hblank_i && !vblank_i && (cy < 10'(MAX_X_SEGMENT))
            && (cx < 10'(MAX_Y_SEGMENT * MAX_Z_SEGMENT)) && col_en_q[id_d.y];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_en_q <= '1;
      id_o     <= '0;
      has_o    <= 1'b0;
    end else begin
      if (mask_wr_i) col_en_q <= mask_data_i;
      id_o  <= id_d;
      has_o <= has_d;
    end
  end
endmodule

// File: rtl/segments_fade.sv
// Per-segment LCD persistence: walker updates every level once per vblank, display path reads them per pixel.
module segments_fade import segments_fade_pkg::*; #(
  parameter int CLOCK_RATIO = 3,
  parameter int LEVEL_BITS  = 8,
  parameter int RISE_STEP   = 64,
  parameter int FALL_STEP   = 16
) (
  input logic            clk,
  input logic            reset,
  segments_fade_if.slave bus
);
  localparam logic [LEVEL_BITS-1:0] LMAX = '1;
  localparam seg_id_t ID_LAST = '{x: XW'(MAX_X_SEGMENT-1), y: YW'(MAX_Y_SEGMENT-1), z: ZW'(MAX_Z_SEGMENT-1)};

  walk_state_e state_q, state_d;
  logic clear_q, clear_d, overrun_q, overrun_d;
  seg_id_t wid_q, wid_d, mid;
  logic vb_q, rd_vld_q, last_q, on_q, fwd_q, has2_q, bin_q, mhas;
  logic [IDX_W-1:0] wr_addr_q, raddr;
  logic [LEVEL_BITS-1:0] fwd_data_q, rdata, old, wdata, lvl;
  logic [LEVEL_BITS:0] sum, diff;
  logic walking, abort, issue, we;

  segments_fade_mask #(.CLOCK_RATIO(CLOCK_RATIO)) u_mask (
    .clk(clk), .reset(reset), .video_x_i(bus.video_x), .video_y_i(bus.video_y),
    .hblank_i(bus.hblank_int), .vblank_i(bus.vblank_int), .mask_wr_i(bus.mask_data_wr),
    .mask_data_i(bus.mask_data), .id_o(mid), .has_o(mhas)
  );

  segments_fade_level_ram #(.W(LEVEL_BITS), .DEPTH(N_SEG), .AW(IDX_W)) u_ram (
    .clk(clk), .we_i(we), .waddr_i(wr_addr_q), .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata)
  );

  // read at idx k while writing k-1; the bypass covers a write landing on the address being read
  always_comb begin
    walking = clear_q || (state_q == W_WALK);
    abort   = !clear_q && (state_q == W_WALK) && !bus.vblank_int;
    issue   = walking && !abort && !(rd_vld_q && last_q);
    we      = rd_vld_q && walking && !abort;
    raddr   = walking ? seg_idx(wid_q) : seg_idx(mid);
    old     = fwd_q ? fwd_data_q : rdata;
    sum     = {1'b0, old} + (LEVEL_BITS+1)'(RISE_STEP);
    diff    = {1'b0, old} - (LEVEL_BITS+1)'(FALL_STEP);
    if (clear_q)               wdata = '0;
    else if (!bus.fade_enable) wdata = on_q ? LMAX : '0;
    else if (on_q)             wdata = sum[LEVEL_BITS] ? LMAX : sum[LEVEL_BITS-1:0];
    else                       wdata = diff[LEVEL_BITS] ? '0 : diff[LEVEL_BITS-1:0];
  end

  always_comb begin
    state_d   = state_q;
    clear_d   = clear_q;
    wid_d     = wid_q;
    overrun_d = overrun_q;
    if (issue) wid_d = seg_id_next(wid_q);
    case (state_q)
      W_IDLE: if (!clear_q && bus.vblank_int && !vb_q) state_d = W_WALK;
      W_WALK: begin
        if (abort) begin
          state_d   = W_IDLE;
          overrun_d = 1'b1;
          wid_d     = '0;
        end else if (we && last_q) state_d = W_DONE;
      end
      W_DONE: if (!bus.vblank_int) state_d = W_IDLE;
      default: state_d = W_IDLE;
    endcase
    if (clear_q && we && last_q) clear_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= W_IDLE;
      clear_q    <= 1'b1;
      wid_q      <= '0;
      vb_q       <= 1'b0;
      rd_vld_q   <= 1'b0;
      last_q     <= 1'b0;
      on_q       <= 1'b0;
      wr_addr_q  <= '0;
      fwd_q      <= 1'b0;
      fwd_data_q <= '0;
      overrun_q  <= 1'b0;
      has2_q     <= 1'b0;
      bin_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      clear_q    <= clear_d;
      wid_q      <= wid_d;
      vb_q       <= bus.vblank_int;
      rd_vld_q   <= issue;
      last_q     <= (wid_q == ID_LAST);
      on_q       <= bus.segments[wid_q.z][wid_q.x][wid_q.y];
      wr_addr_q  <= raddr;
      fwd_q      <= we && (wr_addr_q == raddr);
      fwd_data_q <= wdata;
      overrun_q  <= overrun_d;
      has2_q     <= mhas;
      bin_q      <= mhas && bus.segments[mid.z][mid.x][mid.y];
    end
  end

  // store contents are meaningless until the post-reset clear walk has covered every entry
  always_comb begin
    lvl = '0;
    if (!clear_q && has2_q) lvl = bus.fade_enable ? rdata : (bin_q ? LMAX : '0);
  end

  assign bus.segment_level = lvl;
  assign bus.segment_en    = |lvl;
  assign bus.walk_overrun  = overrun_q;
endmodule
